// File: rtl/fft_sample_loader_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT sample loader: default sample width, the
// supported frame length and the launch FSM state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package fft_pkg;

    localparam int unsigned FFT_SAMPLE_W = 16;
    localparam int unsigned FFT_N_POINTS = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/fft_sample_loader_if.sv
// ----------------------------------------------------------------------------
// fft_sample_loader_if
// Valid/ready streaming sample interface feeding the loader.
//   in_data  : streaming sample (SAMPLE_W bits), source -> loader
//   in_valid : in_data is valid,                 source -> loader
//   in_ready : loader can accept,                loader -> source
// Modports: master = sample source, slave = loader.
// ----------------------------------------------------------------------------
interface fft_sample_loader_if
    import fft_pkg::*;
#(
    parameter int unsigned SAMPLE_W = FFT_SAMPLE_W
);

    logic [SAMPLE_W-1:0] in_data;
    logic                in_valid;
    logic                in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/fft_frame_buffer.sv
// ----------------------------------------------------------------------------
// fft_frame_buffer
// Fill side of the loader: collects N_POINTS streaming samples in arrival
// order into the fill bank, then stalls input until the frame is consumed.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : incoming sample
//   in_valid   : sample valid
//   consume    : frame copied out this edge; clears fill_full
//   in_ready   : !fill_full (registers only, no path from in_valid)
//   fill_full  : a complete frame is waiting in the fill bank
//   fill_bank  : buffered frame, slot 0 = first sample
// ----------------------------------------------------------------------------
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int unsigned SAMPLE_W = FFT_SAMPLE_W,
    parameter int unsigned N_POINTS = FFT_N_POINTS
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [SAMPLE_W-1:0]                in_data,
    input  logic                               in_valid,
    input  logic                               consume,
    output logic                               in_ready,
    output logic                               fill_full,
    output logic [N_POINTS-1:0][SAMPLE_W-1:0]  fill_bank
);

    localparam int unsigned IDX_W = $clog2(N_POINTS);

    logic [IDX_W-1:0] fill_index;
    logic             accept;

    assign in_ready = !fill_full;
    assign accept   = in_valid && !fill_full;

    // consume is only raised while fill_full is set, so it never coincides
    // with an accept; the clearing edge therefore takes no data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_bank  <= '0;
            fill_index <= '0;
            fill_full  <= 1'b0;
        end else begin
            if (accept) begin
                fill_bank[fill_index] <= in_data;
                fill_index            <= fill_index + 1'b1;
                if (fill_index == IDX_W'(N_POINTS - 1)) begin
                    fill_full <= 1'b1;
                end
            end else if (consume) begin
                fill_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fft_sample_loader.sv
// ----------------------------------------------------------------------------
// fft_sample_loader
// Double-buffered frame loader in front of a 4-point FFT core. Samples are
// gathered in a fill bank; a full frame is committed to the hold bank that
// drives the FFT core, and a start/done level handshake sequences the core.
// The next frame prefills while the core runs.
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_if            : streaming sample input (slave modport)
//   sample0..3_out   : held frame to the FFT core
//   fft_start        : start level to the FFT core
//   fft_done         : done level from the FFT core
//   frame_launched   : one-cycle pulse per committed frame
// ----------------------------------------------------------------------------
module fft_sample_loader
    import fft_pkg::*;
#(
    parameter int unsigned SAMPLE_W = FFT_SAMPLE_W,
    parameter int unsigned N_POINTS = FFT_N_POINTS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_sample_loader_if.slave   in_if,
    output logic [SAMPLE_W-1:0]  sample0_out,
    output logic [SAMPLE_W-1:0]  sample1_out,
    output logic [SAMPLE_W-1:0]  sample2_out,
    output logic [SAMPLE_W-1:0]  sample3_out,
    output logic                 fft_start,
    input  logic                 fft_done,
    output logic                 frame_launched
);

    generate
        if (N_POINTS != 4) begin : g_bad_n_points
            $error("fft_sample_loader: only N_POINTS = 4 is supported");
        end
    endgenerate

    loader_state_t                        state;
    logic [N_POINTS-1:0][SAMPLE_W-1:0]    fill_bank;
    logic [N_POINTS-1:0][SAMPLE_W-1:0]    hold_bank;
    logic                                 fill_full;
    logic                                 commit;

    assign commit = (state == ST_IDLE) && fill_full && !fft_done;

    fft_frame_buffer #(
        .SAMPLE_W (SAMPLE_W),
        .N_POINTS (N_POINTS)
    ) u_frame_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_if.in_data),
        .in_valid  (in_if.in_valid),
        .consume   (commit),
        .in_ready  (in_if.in_ready),
        .fill_full (fill_full),
        .fill_bank (fill_bank)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            hold_bank      <= '0;
            fft_start      <= 1'b0;
            frame_launched <= 1'b0;
        end else begin
            frame_launched <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (commit) begin
                        hold_bank      <= fill_bank;
                        fft_start      <= 1'b1;
                        frame_launched <= 1'b1;
                        state          <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fft_done) begin
                        fft_start <= 1'b0;
                        state     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Wait for the core to drop done so one done level can
                    // never be mistaken for completion of the next frame.
                    if (!fft_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    fft_start <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign sample0_out = hold_bank[0];
    assign sample1_out = hold_bank[1];
    assign sample2_out = hold_bank[2];
    assign sample3_out = hold_bank[3];

endmodule

// File: tb/tb_fft_sample_loader.sv
module tb_fft_sample_loader;

    logic        clk;
    logic        rst_n;
    logic        fft_done;
    logic        fft_start;
    logic        frame_launched;
    logic [15:0] sample0_out, sample1_out, sample2_out, sample3_out;
    logic [63:0] hold_cat;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    fft_sample_loader_if #(.SAMPLE_W(16)) s_if ();

    fft_sample_loader #(
        .SAMPLE_W (16),
        .N_POINTS (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_if          (s_if),
        .sample0_out    (sample0_out),
        .sample1_out    (sample1_out),
        .sample2_out    (sample2_out),
        .sample3_out    (sample3_out),
        .fft_start      (fft_start),
        .fft_done       (fft_done),
        .frame_launched (frame_launched)
    );

    assign hold_cat = {sample0_out, sample1_out, sample2_out, sample3_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        done;
        logic        rdy;
        logic        start;
        logic        launch;
        logic [63:0] hold;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic done);
        s_if.in_valid = v;
        s_if.in_data  = d;
        fft_done      = done;
    endtask

    // Called just after an edge; reset is asserted and released between edges.
    task automatic pulse_reset(input string name);
        rst_n = 1'b0;
        #1;
        check({name, "_start"},  64'(fft_start), 64'd0);
        check({name, "_launch"}, 64'(frame_launched), 64'd0);
        check({name, "_hold"},   hold_cat, 64'd0);
        check({name, "_rdy"},    64'(s_if.in_ready), 64'd1);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [63:0] f, input logic done);
        logic [15:0] w;
        for (int i = 0; i < 4; i++) begin
            w = f[63 - 16*i -: 16];
            drive(1'b1, w, done);
            step();
        end
        drive(1'b0, 16'h0000, done);
    endtask

    localparam logic [63:0] H1 = 64'h0001_0002_0003_0004;
    localparam logic [63:0] H2 = 64'h0010_0011_0012_0013;
    localparam logic [63:0] HR = 64'hAAAA_5555_8000_7FFF;
    localparam logic [63:0] HS = 64'h1111_2222_3333_4444;

    initial begin
        int unsigned acc, launches, cnt, age;
        logic        done_r, acc_now;
        logic [15:0] nxt, b;

        //           v    d         done  rdy   start launch hold
        vecs[0]  = '{1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0};
        vecs[1]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0};
        vecs[2]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0};
        vecs[3]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, H1};
        vecs[5]  = '{1'b1, 16'h0010, 1'b0, 1'b1, 1'b1, 1'b0, H1};
        vecs[6]  = '{1'b1, 16'h0011, 1'b0, 1'b1, 1'b1, 1'b0, H1};
        vecs[7]  = '{1'b1, 16'h0012, 1'b1, 1'b1, 1'b0, 1'b0, H1};
        vecs[8]  = '{1'b1, 16'h0013, 1'b1, 1'b0, 1'b0, 1'b0, H1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, H1};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, H2};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, H2};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, H2};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, H2};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, H2};

        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 1'b0);
        #2;
        check("reset_start",  64'(fft_start), 64'd0);
        check("reset_launch", 64'(frame_launched), 64'd0);
        check("reset_hold",   hold_cat, 64'd0);
        check("reset_rdy",    64'(s_if.in_ready), 64'd1);
        #10;
        rst_n = 1'b1;

        // Basic launch, done handshake and prefill under load.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].done);
            step();
            check($sformatf("vec%0d_rdy", i),    64'(s_if.in_ready),    64'(vecs[i].rdy));
            check($sformatf("vec%0d_start", i),  64'(fft_start),        64'(vecs[i].start));
            check($sformatf("vec%0d_launch", i), 64'(frame_launched),   64'(vecs[i].launch));
            check($sformatf("vec%0d_hold", i),   hold_cat,              vecs[i].hold);
        end

        // Partial frame never launches.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0F00 + 16'(i), 1'b0);
            step();
        end
        drive(1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 8; i++) step();
        check("partial_start", 64'(fft_start), 64'd0);
        check("partial_rdy",   64'(s_if.in_ready), 64'd1);
        check("partial_hold",  hold_cat, H2);

        // Reset after 2 samples of a new frame (on top of the partial one).
        pulse_reset("rst_partial");
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'h0BAD + 16'(i), 1'b0);
            step();
        end
        drive(1'b0, 16'h0000, 1'b0);
        pulse_reset("rst_two");
        send_frame(HR, 1'b0);
        check("rst_frame_rdy", 64'(s_if.in_ready), 64'd0);
        step();
        check("rst_frame_launch", 64'(frame_launched), 64'd1);
        check("rst_frame_start",  64'(fft_start), 64'd1);
        check("rst_frame_hold",   hold_cat, HR);

        // Reset during RUN: no residual start.
        step();
        pulse_reset("rst_run");
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post_rst_start%0d", i), 64'(fft_start), 64'd0);
            check($sformatf("post_rst_launch%0d", i), 64'(frame_launched), 64'd0);
        end
        send_frame(HR, 1'b0);
        step();
        check("rst_run_relaunch", 64'(frame_launched), 64'd1);
        check("rst_run_hold",     hold_cat, HR);

        // Stuck done: full frame waits in IDLE until done falls.
        pulse_reset("rst_stuck");
        send_frame(HS, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stuck%0d_start", i), 64'(fft_start), 64'd0);
            check($sformatf("stuck%0d_rdy", i),   64'(s_if.in_ready), 64'd0);
            check($sformatf("stuck%0d_hold", i),  hold_cat, 64'd0);
        end
        fft_done = 1'b0;
        step();
        check("stuck_release_launch", 64'(frame_launched), 64'd1);
        check("stuck_release_start",  64'(fft_start), 64'd1);
        check("stuck_release_hold",   hold_cat, HS);
        step();
        check("stuck_pulse_width", 64'(frame_launched), 64'd0);

        // Backpressure: in_valid held high across 3 frames with an FFT model.
        pulse_reset("rst_bp");
        acc = 0; launches = 0; cnt = 0; age = 0;
        done_r = 1'b0;
        nxt = 16'h0100;
        for (int cyc = 0; cyc < 300 && launches < 3; cyc++) begin
            drive(acc < 12, nxt, done_r);
            acc_now = s_if.in_valid && s_if.in_ready;
            step();
            if (acc_now) begin
                acc++;
                cnt++;
                nxt = nxt + 16'd1;
            end
            if (frame_launched) begin
                b = 16'h0100 + 16'(4 * launches);
                check($sformatf("bp_frame%0d", launches), hold_cat,
                      {b, b + 16'd1, b + 16'd2, b + 16'd3});
                launches++;
                cnt = cnt - 4;
            end
            check($sformatf("bp_rdy_c%0d", cyc), 64'(s_if.in_ready), 64'(cnt != 4));
            if (fft_start) begin
                if (!done_r) begin
                    age++;
                    if (age >= 3) done_r = 1'b1;
                end
            end else begin
                age = 0;
                done_r = 1'b0;
            end
        end
        drive(1'b0, 16'h0000, 1'b0);
        check("bp_accepts",  64'(acc), 64'd12);
        check("bp_launches", 64'(launches), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_sample_loader.md
FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, the width of the sample and data ports.
REQ-002 SHALL have parameter N_POINTS, default 4, frame length; only 4 is supported, and any other value SHALL fail elaboration.
REQ-003 SHALL have port clk, input, 1 bit; the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have port in_data, input, SAMPLE_W bits; streaming sample.
REQ-006 SHALL have port in_valid, input, 1 bit; in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit; loader can accept; a transfer occurs when in_valid and in_ready are both high at posedge.
REQ-008 SHALL have ports sample0_out, sample1_out, sample2_out and sample3_out, outputs, SAMPLE_W bits each; the held frame driven to the FFT core.
REQ-009 SHALL have port fft_start, output, 1 bit; start level to the FFT core.
REQ-010 SHALL have port fft_done, input, 1 bit; done level from the FFT core.
REQ-011 SHALL have port frame_launched, output, 1 bit; one-cycle pulse per committed frame.

Function
REQ-012 SHALL contain a fill bank (4 x SAMPLE_W), a 2-bit fill index, a fill_full flag and a hold bank (4 x SAMPLE_W) that drives sample0_out..sample3_out.
REQ-013 SHALL write each accepted sample to fill-bank slot fill_index, in arrival order: 1st -> slot 0, ..., 4th -> slot 3; fill_index wraps 3 -> 0 and fill_full sets on the 4th accept.
REQ-014 SHALL drive in_ready = !fill_full, combinationally from registers only with no path from in_valid, so the next frame prefills while the FFT runs.
REQ-015 SHALL implement the launch FSM with states IDLE, RUN and RELEASE, reset to IDLE.
REQ-016 IDLE: when fill_full=1 and fft_done=0, SHALL commit at the next edge: copy fill bank to hold bank, clear fill_full, set fft_start=1, pulse frame_launched, go to RUN.
REQ-017 RUN: SHALL hold fft_start=1 and the hold bank stable; on fft_done=1 it SHALL clear fft_start at the next edge and go to RELEASE.
REQ-018 RELEASE: SHALL hold fft_start=0; on fft_done=0 it SHALL go to IDLE at the next edge.
REQ-019 Latency: 4th accept at edge k -> commit at edge k+1 when IDLE and fft_done=0; otherwise commit on the first edge after the FSM re-enters IDLE.
REQ-020 Hold-bank registers SHALL change only on a commit edge.
REQ-021 fill_full=1 SHALL stall input (in_ready=0) until commit; the edge that clears fill_full SHALL NOT accept data.
REQ-022 A partial frame (fewer than 4 samples) SHALL never launch; it remains buffered indefinitely.
REQ-023 fft_done=1 in IDLE SHALL block a commit until fft_done falls.
REQ-024 Arithmetic: none on sample data; values SHALL pass bit-exact with no sign or width change.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear fill bank, hold bank, sample0_out..sample3_out, fill_index, fill_full, fft_start and frame_launched to 0, and set the FSM to IDLE.
REQ-026 After rst_n deasserts, in_ready=1 from the first edge.
REQ-027 Reset mid-frame SHALL discard the partial fill and any in-flight launch, with no residual pulse on fft_start.

Structure
REQ-028 A shared package fft_pkg SHALL hold the SAMPLE_W default, N_POINTS and the loader FSM state enum.
REQ-029 The fill bank with its index and flag SHALL be a single sub-module named fft_frame_buffer; the FSM and hold bank stay in fft_sample_loader.

Verification
REQ-030 Basic launch: after reset, stream 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles -> in_ready falls after the 4th; next edge gives sample0_out..sample3_out = 1, 2, 3, 4, fft_start=1 and frame_launched high for 1 cycle.
REQ-031 Handshake with the FFT model: done rises 3 cycles after start -> fft_start falls 1 cycle after done rises; FSM waits for done=0 before any new start.
REQ-032 Prefill under load: send frame 0x0010..0x0013 during RUN -> hold bank keeps the first frame until RELEASE->IDLE, then loads 0x0010..0x0013 and launches.
REQ-033 Backpressure: hold in_valid=1 continuously across 3 frames -> in_ready=0 whenever fill_full=1, no sample lost or duplicated, exactly 12 accepts and 3 launches.
REQ-034 Reset mid-operation: assert rst_n=0 after 2 samples, and again during RUN -> all outputs 0 asynchronously, in_ready=1 afterwards; the next 4 samples (0xAAAA, 0x5555, 0x8000, 0x7FFF) launch unmodified.
REQ-035 Stuck done: hold fft_done=1 while IDLE with a full frame -> no commit and fft_start stays 0 until done falls; launch occurs on the next edge after that.
